// File: rtl/maxnet_data_memory_if.sv
// Purpose: bus bundle between the Maxnet controller/datapath (master) and the
//          data memory (slave).
// Signals:
//   write_en / write_address / write_data        single write port request
//   read_en_a / read_address_a                   read port A request
//   read_en_b / read_address_b                   read port B request
//   read_data_a / read_valid_a                   port A registered response
//   read_data_b / read_valid_b                   port B registered response
//   busy                                         init reload in progress
//   addr_error                                   sticky out-of-range flag
interface maxnet_data_memory_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 2
);

  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;

  logic                  read_en_a;
  logic [ADDR_WIDTH-1:0] read_address_a;
  logic                  read_en_b;
  logic [ADDR_WIDTH-1:0] read_address_b;

  logic [DATA_WIDTH-1:0] read_data_a;
  logic                  read_valid_a;
  logic [DATA_WIDTH-1:0] read_data_b;
  logic                  read_valid_b;

  logic                  busy;
  logic                  addr_error;

  // Requester side: drives the access requests, observes responses.
  modport master (
    output write_en, write_address, write_data,
    output read_en_a, read_address_a, read_en_b, read_address_b,
    input  read_data_a, read_valid_a, read_data_b, read_valid_b,
    input  busy, addr_error
  );

  // Memory side: consumes requests, produces registered responses.
  modport slave (
    input  write_en, write_address, write_data,
    input  read_en_a, read_address_a, read_en_b, read_address_b,
    output read_data_a, read_valid_a, read_data_b, read_valid_b,
    output busy, addr_error
  );

endinterface

// File: rtl/maxnet_data_memory.sv
// Purpose: Maxnet data memory. After every reset an init sequencer copies the
//          build-time image into the array, one word per cycle, then the array
//          serves one write port (write-first bypass onto reads) and two
//          independent registered read ports. A sticky flag records any
//          enabled access whose address is outside 0..DEPTH-1.
// Parameters:
//   DATA_WIDTH  bits per word
//   DEPTH       number of words (>= 2, any value)
//   ADDR_WIDTH  address width, $clog2(DEPTH)
//   INIT_IMAGE  build-time image, produced from the hex image file when the
//               design is elaborated; word i sits in
//               bits [i*DATA_WIDTH +: DATA_WIDTH]. Read only, never written back.
// Ports:
//   i_clock     rising-edge clock
//   i_reset     synchronous active-high reset; restarts the init sequence
//   bus         maxnet_data_memory_if slave modport (requests in, responses out)
module maxnet_data_memory #(
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    DEPTH      = 4,
  parameter int unsigned                    ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DEPTH*DATA_WIDTH-1:0]    INIT_IMAGE = '0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  maxnet_data_memory_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_read_data_a;
  logic [DATA_WIDTH-1:0] r_read_data_b;
  logic                  r_read_valid_a;
  logic                  r_read_valid_b;
  logic                  r_addr_error;

  logic [DATA_WIDTH-1:0] w_rom [DEPTH];
  logic                  w_wr_in_range;
  logic                  w_rd_a_in_range;
  logic                  w_rd_b_in_range;
  logic                  w_wr_ok;
  logic                  w_rd_a_ok;
  logic                  w_rd_b_ok;
  logic                  w_bypass_a;
  logic                  w_bypass_b;
  logic                  w_range_err;

  // Image ROM: fixed slices of the build-time image.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign w_rom[g] = INIT_IMAGE[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Address range decode; DEPTH need not fill the address space.
  assign w_wr_in_range   = 32'(bus.write_address)  < DEPTH;
  assign w_rd_a_in_range = 32'(bus.read_address_a) < DEPTH;
  assign w_rd_b_in_range = 32'(bus.read_address_b) < DEPTH;

  assign w_wr_ok   = bus.write_en  & w_wr_in_range;
  assign w_rd_a_ok = bus.read_en_a & w_rd_a_in_range;
  assign w_rd_b_ok = bus.read_en_b & w_rd_b_in_range;

  // A read hitting the word being written this edge returns the new data.
  assign w_bypass_a = w_wr_ok & w_rd_a_ok & (bus.write_address == bus.read_address_a);
  assign w_bypass_b = w_wr_ok & w_rd_b_ok & (bus.write_address == bus.read_address_b);

  assign w_range_err = (bus.write_en  & ~w_wr_in_range)
                     | (bus.read_en_a & ~w_rd_a_in_range)
                     | (bus.read_en_b & ~w_rd_b_in_range);

  // Init/ready sequencer, storage array and registered read ports.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // Array contents are deliberately left alone; the next init pass reloads them.
      r_state        <= ST_INIT;
      r_ptr          <= '0;
      r_busy         <= 1'b1;
      r_read_data_a  <= '0;
      r_read_data_b  <= '0;
      r_read_valid_a <= 1'b0;
      r_read_valid_b <= 1'b0;
      r_addr_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          // User accesses are ignored entirely while the image is reloaded.
          r_mem[r_ptr]   <= w_rom[r_ptr];
          r_read_valid_a <= 1'b0;
          r_read_valid_b <= 1'b0;
          if (r_ptr == LP_LAST_PTR) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
          end
        end

        ST_READY: begin
          if (w_wr_ok) begin
            r_mem[bus.write_address] <= bus.write_data;
          end

          // Port A: valid pulses per accepted read, data holds otherwise.
          r_read_valid_a <= w_rd_a_ok;
          if (w_rd_a_ok) begin
            r_read_data_a <= w_bypass_a ? bus.write_data : r_mem[bus.read_address_a];
          end

          // Port B: identical to port A.
          r_read_valid_b <= w_rd_b_ok;
          if (w_rd_b_ok) begin
            r_read_data_b <= w_bypass_b ? bus.write_data : r_mem[bus.read_address_b];
          end

          // Sticky until the next reset.
          if (w_range_err) begin
            r_addr_error <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.read_data_a  = r_read_data_a;
  assign bus.read_data_b  = r_read_data_b;
  assign bus.read_valid_a = r_read_valid_a;
  assign bus.read_valid_b = r_read_valid_b;
  assign bus.addr_error   = r_addr_error;

endmodule

// File: tb/tb_maxnet_data_memory.sv
// Bench for maxnet_data_memory: one DEPTH=4 instance and one DEPTH=3 instance
// (address 3 out of range), checked every cycle against a word-array model,
// plus hand-computed expectations for the directed scenarios.
module tb_maxnet_data_memory;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;
  localparam logic [4*DW-1:0] IMG0 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [3*DW-1:0] IMG1 = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  maxnet_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  maxnet_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  maxnet_data_memory #(
    .DATA_WIDTH(DW), .DEPTH(4), .ADDR_WIDTH(AW), .INIT_IMAGE(IMG0)
  ) u_dut0 (
    .i_clock(clk), .i_reset(rst0), .bus(if0)
  );

  maxnet_data_memory #(
    .DATA_WIDTH(DW), .DEPTH(3), .ADDR_WIDTH(AW), .INIT_IMAGE(IMG1)
  ) u_dut1 (
    .i_clock(clk), .i_reset(rst1), .bus(if1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int          m_depth [2];
  logic [31:0] m_img   [2][4];
  logic [31:0] m_mem   [2][4];
  int          m_left  [2];     // init words still to be loaded
  bit          m_known [2];
  logic [31:0] m_rda   [2];
  logic [31:0] m_rdb   [2];
  bit          m_va    [2];
  bit          m_vb    [2];
  bit          m_err   [2];

  task automatic model_edge(input int d, input logic rst,
                            input logic we, input logic [1:0] wa, input logic [31:0] wd,
                            input logic rea, input logic [1:0] raa,
                            input logic reb, input logic [1:0] rab);
    int dep;
    int k;
    bit wok, aok, bok;
    dep = m_depth[d];
    if (rst) begin
      m_known[d] = 1'b1;
      m_left[d]  = dep;
      m_rda[d] = '0; m_rdb[d] = '0;
      m_va[d] = 1'b0; m_vb[d] = 1'b0; m_err[d] = 1'b0;
    end else if (m_known[d]) begin
      if (m_left[d] > 0) begin
        k = dep - m_left[d];
        m_mem[d][k] = m_img[d][k];
        m_left[d]--;
        m_va[d] = 1'b0; m_vb[d] = 1'b0;
      end else begin
        wok = we  && (int'(wa)  < dep);
        aok = rea && (int'(raa) < dep);
        bok = reb && (int'(rab) < dep);
        m_va[d] = aok;
        m_vb[d] = bok;
        if (aok) m_rda[d] = (wok && wa == raa) ? wd : m_mem[d][raa];
        if (bok) m_rdb[d] = (wok && wa == rab) ? wd : m_mem[d][rab];
        if ((we && !wok) || (rea && !aok) || (reb && !bok)) m_err[d] = 1'b1;
        if (wok) m_mem[d][wa] = wd;
      end
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, rst0, if0.write_en, if0.write_address, if0.write_data,
               if0.read_en_a, if0.read_address_a, if0.read_en_b, if0.read_address_b);
    model_edge(1, rst1, if1.write_en, if1.write_address, if1.write_data,
               if1.read_en_a, if1.read_address_a, if1.read_en_b, if1.read_address_b);
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_dut(input int d, input logic busy, input logic va, input logic vb,
                         input logic err, input logic [31:0] rda, input logic [31:0] rdb);
    string p;
    p = (d == 0) ? "dut0" : "dut1";
    chk({p, " busy"},       32'(busy), 32'(m_left[d] > 0));
    chk({p, " valid_a"},    32'(va),   32'(m_va[d]));
    chk({p, " valid_b"},    32'(vb),   32'(m_vb[d]));
    chk({p, " addr_error"}, 32'(err),  32'(m_err[d]));
    chk({p, " data_a"},     rda,       m_rda[d]);
    chk({p, " data_b"},     rdb,       m_rdb[d]);
  endtask

  always @(negedge clk) begin
    if (m_known[0]) cmp_dut(0, if0.busy, if0.read_valid_a, if0.read_valid_b,
                            if0.addr_error, if0.read_data_a, if0.read_data_b);
    if (m_known[1]) cmp_dut(1, if1.busy, if1.read_valid_a, if1.read_valid_b,
                            if1.addr_error, if1.read_data_a, if1.read_data_b);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_all();
    if0.write_en = 1'b0; if0.read_en_a = 1'b0; if0.read_en_b = 1'b0;
    if1.write_en = 1'b0; if1.read_en_a = 1'b0; if1.read_en_b = 1'b0;
  endtask

  // Counts negedge samples with busy high, starting at the current negedge.
  task automatic count_busy(input int d, output int n);
    n = 0;
    while ((((d == 0) ? if0.busy : if1.busy) !== 1'b0) && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_a0(input logic [1:0] a, input logic [31:0] exp, input string name);
    if0.read_en_a = 1'b1; if0.read_address_a = a;
    @(negedge clk);
    chk({name, " data"},  if0.read_data_a, exp);
    chk({name, " valid"}, 32'(if0.read_valid_a), 32'd1);
    if0.read_en_a = 1'b0;
  endtask

  task automatic read_a1(input logic [1:0] a, input logic [31:0] exp, input string name);
    if1.read_en_a = 1'b1; if1.read_address_a = a;
    @(negedge clk);
    chk({name, " data"},  if1.read_data_a, exp);
    chk({name, " valid"}, 32'(if1.read_valid_a), 32'd1);
    if1.read_en_a = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m_depth[0] = 4; m_depth[1] = 3;
    for (int i = 0; i < 4; i++) begin
      m_img[0][i] = IMG0[i*32 +: 32];
      m_img[1][i] = (i < 3) ? IMG1[i*32 +: 32] : 32'h0;
      m_known[0] = 1'b0; m_known[1] = 1'b0;
    end
    rst0 = 1'b1; rst1 = 1'b1;
    if0.write_address = '0; if0.write_data = '0; if0.read_address_a = '0; if0.read_address_b = '0;
    if1.write_address = '0; if1.write_data = '0; if1.read_address_a = '0; if1.read_address_b = '0;
    idle_all();

    // Reset state and init length.
    @(negedge clk);
    chk("reset busy",       32'(if0.busy), 32'd1);
    chk("reset valid_a",    32'(if0.read_valid_a), 32'd0);
    chk("reset data_a",     if0.read_data_a, 32'd0);
    chk("reset addr_error", 32'(if0.addr_error), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    count_busy(0, n);
    chk("init busy cycles", 32'(n), 32'd4);

    // Image read back in order, one valid pulse each.
    read_a0(2'd0, 32'h11111111, "init rd0");
    read_a0(2'd1, 32'h22222222, "init rd1");
    read_a0(2'd2, 32'h33333333, "init rd2");
    read_a0(2'd3, 32'h44444444, "init rd3");
    @(negedge clk);
    chk("valid_a single pulse", 32'(if0.read_valid_a), 32'd0);

    // Write then read on port B.
    if0.write_en = 1'b1; if0.write_address = 2'd2; if0.write_data = 32'hDEADBEEF;
    @(negedge clk);
    if0.write_en = 1'b0;
    if0.read_en_b = 1'b1; if0.read_address_b = 2'd2;
    @(negedge clk);
    chk("write/read B", if0.read_data_b, 32'hDEADBEEF);
    if0.read_en_b = 1'b0;

    // Reset restores the image.
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    count_busy(0, n);
    chk("restore ready", 32'(n), 32'd4);
    read_a0(2'd2, 32'h33333333, "restore rd2");

    // Bypass onto both ports, then a split dual read.
    if0.write_en = 1'b1; if0.write_address = 2'd1; if0.write_data = 32'hCAFEF00D;
    if0.read_en_a = 1'b1; if0.read_address_a = 2'd1;
    if0.read_en_b = 1'b1; if0.read_address_b = 2'd1;
    @(negedge clk);
    chk("bypass A", if0.read_data_a, 32'hCAFEF00D);
    chk("bypass B", if0.read_data_b, 32'hCAFEF00D);
    if0.write_en = 1'b0;
    if0.read_address_a = 2'd0; if0.read_address_b = 2'd3;
    @(negedge clk);
    chk("dual A", if0.read_data_a, 32'h11111111);
    chk("dual B", if0.read_data_b, 32'h44444444);
    idle_all();

    // Accesses during init are ignored.
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    if0.write_en = 1'b1; if0.write_address = 2'd0; if0.write_data = 32'hFFFFFFFF;
    if0.read_en_a = 1'b1; if0.read_address_a = 2'd0;
    n = 0;
    while (if0.busy !== 1'b0 && n < 20) begin
      chk("no valid while busy", 32'(if0.read_valid_a), 32'd0);
      n++;
      @(negedge clk);
    end
    idle_all();
    chk("busy init cycles", 32'(n), 32'd4);
    read_a0(2'd0, 32'h11111111, "init-write dropped");

    // Reset reasserted with ptr=2.
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    count_busy(0, n);
    chk("mid-init restart cycles", 32'(n), 32'd4);
    read_a0(2'd0, 32'h11111111, "restart rd0");
    read_a0(2'd1, 32'h22222222, "restart rd1");
    read_a0(2'd2, 32'h33333333, "restart rd2");
    read_a0(2'd3, 32'h44444444, "restart rd3");

    // Out of range on the DEPTH=3 instance.
    if1.write_en = 1'b1; if1.write_address = 2'd3; if1.write_data = 32'h12345678;
    @(negedge clk);
    if1.write_en = 1'b0;
    chk("oor write err", 32'(if1.addr_error), 32'd1);
    @(negedge clk);
    chk("oor err sticky", 32'(if1.addr_error), 32'd1);
    read_a1(2'd0, 32'hA0A0A0A0, "oor rd0");
    read_a1(2'd1, 32'hB1B1B1B1, "oor rd1");
    read_a1(2'd2, 32'hC2C2C2C2, "oor rd2");
    if1.read_en_a = 1'b1; if1.read_address_a = 2'd3;
    @(negedge clk);
    if1.read_en_a = 1'b0;
    chk("oor read no valid", 32'(if1.read_valid_a), 32'd0);
    chk("oor read data held", if1.read_data_a, 32'hC2C2C2C2);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("reset clears err", 32'(if1.addr_error), 32'd0);
    count_busy(1, n);
    chk("depth3 init cycles", 32'(n), 32'd3);

    // Randomized traffic on both instances, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst0 = ($urandom_range(63) == 0);
      rst1 = ($urandom_range(63) == 0);
      if0.write_en = 1'($urandom_range(1)); if0.write_address = 2'($urandom_range(3));
      if0.write_data = $urandom;
      if0.read_en_a = 1'($urandom_range(1)); if0.read_address_a = 2'($urandom_range(3));
      if0.read_en_b = 1'($urandom_range(1)); if0.read_address_b = 2'($urandom_range(3));
      if1.write_en = ($urandom_range(7) < 3); if1.write_address = 2'($urandom_range(3));
      if1.write_data = $urandom;
      if1.read_en_a = 1'($urandom_range(1)); if1.read_address_a = 2'($urandom_range(3));
      if1.read_en_b = 1'($urandom_range(1)); if1.read_address_b = 2'($urandom_range(3));
      @(negedge clk);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    idle_all();
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
